// File: rtl/pe_row_seq.sv
// One row of the systolic matrix engine: N unsigned MAC lanes fed by a skewed left
// operand pipeline, with a job sequencer and a serial valid/ready result drain.
module pe_row_seq #(
    parameter int unsigned N   = 16,
    parameter int unsigned DW  = 8,
    parameter int unsigned AW  = 24,
    parameter int unsigned SAT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [15:0]     k_len,
    output logic            busy,
    input  logic [DW-1:0]   left_in,
    input  logic            left_vld,
    input  logic [N*DW-1:0] up_in,
    output logic [N*DW-1:0] down_out,
    output logic [AW-1:0]   out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_last,
    output logic            done
);

    localparam int unsigned CW = $clog2(N);
    localparam int unsigned PW = 2 * DW;
    localparam int unsigned SW = AW + 1;
    localparam int unsigned KW = 16;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACC   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [KW-1:0] k_q, beat_q;
    logic [CW-1:0] flush_q, idx_q;
    logic [DW-1:0] lp_q [N-1];
    logic [N-2:0]  vp_q;
    logic [AW-1:0] acc_q [N];

    logic          job_start, beat_acc, drain_load, drain_step, drain_end;
    logic [DW-1:0] lane_l [N];
    logic [N-1:0]  lane_v;

    // Multiply-accumulate with optional clamp at all-ones
    function automatic logic [AW-1:0] mac(input logic [AW-1:0] acc,
                                          input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
        logic [PW-1:0] prod;
        logic [SW-1:0] sum;
        prod = PW'(a) * PW'(b);
        sum  = {1'b0, acc} + SW'(prod);
        if ((SAT != 0) && sum[AW]) begin
            return '1;
        end
        return sum[AW-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        job_start  = 1'b0;
        beat_acc   = 1'b0;
        drain_load = 1'b0;
        drain_step = 1'b0;
        drain_end  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    job_start = 1'b1;
                    if (k_len == '0) begin
                        drain_load = 1'b1;
                        state_d    = S_DRAIN;
                    end else begin
                        state_d = S_ACC;
                    end
                end
            end
            S_ACC: begin
                if (left_vld) begin
                    beat_acc = 1'b1;
                    if (KW'(beat_q + KW'(1)) == k_q) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (flush_q == CW'(N - 2)) begin
                    drain_load = 1'b1;
                    state_d    = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_valid && out_ready) begin
                    if (idx_q == CW'(N - 1)) begin
                        drain_end = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        drain_step = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Lane j sees the left operand and its valid bit j cycles late
    always_comb begin
        lane_l[0] = left_in;
        lane_v[0] = beat_acc;
        for (int j = 1; j < N; j++) begin
            lane_l[j] = lp_q[j-1];
            lane_v[j] = vp_q[j-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_q     <= '0;
            beat_q  <= '0;
            flush_q <= '0;
            idx_q   <= '0;
            vp_q    <= '0;
            for (int j = 0; j < N - 1; j++) begin
                lp_q[j] <= '0;
            end
            for (int j = 0; j < N; j++) begin
                acc_q[j] <= '0;
            end
        end else begin
            if (job_start) begin
                k_q    <= k_len;
                beat_q <= '0;
            end else if (beat_acc) begin
                beat_q <= KW'(beat_q + KW'(1));
            end
            flush_q <= (state_q == S_FLUSH) ? CW'(flush_q + CW'(1)) : '0;
            if (drain_load) begin
                idx_q <= '0;
            end else if (drain_step) begin
                idx_q <= CW'(idx_q + CW'(1));
            end
            lp_q[0] <= left_in;
            vp_q[0] <= beat_acc;
            for (int j = 1; j < N - 1; j++) begin
                lp_q[j] <= lp_q[j-1];
                vp_q[j] <= vp_q[j-1];
            end
            for (int j = 0; j < N; j++) begin
                if (job_start) begin
                    acc_q[j] <= '0;
                end else if (lane_v[j]) begin
                    acc_q[j] <= mac(acc_q[j], lane_l[j], up_in[(N-j)*DW-1 -: DW]);
                end
            end
        end
    end

    // Registered outputs; the drain word is preloaded so it is stable while waiting for ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            down_out  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            busy     <= (state_d != S_IDLE);
            done     <= drain_end;
            down_out <= up_in;
            if (drain_load) begin
                out_valid <= 1'b1;
                out_last  <= 1'b0;
                out_data  <= job_start ? '0 : acc_q[0];
            end else if (drain_step) begin
                out_data <= acc_q[CW'(idx_q + CW'(1))];
                out_last <= (idx_q == CW'(N - 2));
            end else if (drain_end) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                out_data  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pe_row_seq.sv
// Scoreboard bench for pe_row_seq: one 24-bit wrap row and two 16-bit rows (sat/wrap) share stimulus.
module tb_pe_row_seq;

    localparam int unsigned N  = 16;
    localparam int unsigned DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [15:0]     k_len;
    logic [DW-1:0]   left_in;
    logic            left_vld;
    logic [N*DW-1:0] up_in;
    logic            out_ready;

    logic            m_busy, s_busy, w_busy;
    logic [N*DW-1:0] m_down, s_down, w_down;
    logic [23:0]     m_data;
    logic [15:0]     s_data, w_data;
    logic            m_valid, s_valid, w_valid;
    logic            m_last, s_last, w_last;
    logic            m_done, s_done, w_done;

    int checks = 0;
    int failures = 0;
    int words_main = 0;

    logic [24:0] q_m[$];
    logic [24:0] q_s[$];
    logic [24:0] q_w[$];

    logic [N*DW-1:0] up_prev;
    logic            dn_ok = 1'b0;

    always #5 clk = ~clk;

    pe_row_seq #(.N(N), .DW(DW), .AW(24), .SAT(0)) u_m (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(m_busy),
        .left_in(left_in), .left_vld(left_vld), .up_in(up_in), .down_out(m_down),
        .out_data(m_data), .out_valid(m_valid), .out_ready(out_ready),
        .out_last(m_last), .done(m_done));

    pe_row_seq #(.N(N), .DW(DW), .AW(16), .SAT(1)) u_s (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(s_busy),
        .left_in(left_in), .left_vld(left_vld), .up_in(up_in), .down_out(s_down),
        .out_data(s_data), .out_valid(s_valid), .out_ready(out_ready),
        .out_last(s_last), .done(s_done));

    pe_row_seq #(.N(N), .DW(DW), .AW(16), .SAT(0)) u_w (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(w_busy),
        .left_in(left_in), .left_vld(left_vld), .up_in(up_in), .down_out(w_down),
        .out_data(w_data), .out_valid(w_valid), .out_ready(out_ready),
        .out_last(w_last), .done(w_done));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference sum of k identical beats, with wrap or clamp per beat
    function automatic logic [23:0] model(input int aw, input bit sat, input int k,
                                          input int l, input int u);
        longint s;
        longint mx;
        s  = 0;
        mx = (longint'(1) << aw) - 1;
        for (int b = 0; b < k; b++) begin
            s = s + longint'(l) * longint'(u);
            if (s > mx) s = sat ? mx : (s & mx);
        end
        return 24'(s);
    endfunction

    function automatic logic [N*DW-1:0] fill(input int v);
        logic [N*DW-1:0] r;
        for (int j = 0; j < N; j++) r[(N-j)*DW-1 -: DW] = DW'(v);
        return r;
    endfunction

    function automatic logic [N*DW-1:0] ramp(input int base);
        logic [N*DW-1:0] r;
        for (int j = 0; j < N; j++) r[(N-j)*DW-1 -: DW] = DW'(base + j);
        return r;
    endfunction

    // Scoreboard consumers: one per instance, popping on each handshake edge
    always @(negedge clk) begin
        if (rst && m_valid && out_ready) begin
            if (q_m.size() == 0) chk("m_extra_word", 1, 0);
            else begin
                logic [24:0] e;
                e = q_m.pop_front();
                chk("m_data", 128'(m_data), 128'(e[23:0]));
                chk("m_last", 128'(m_last), 128'(e[24]));
            end
            words_main++;
        end
    end

    always @(negedge clk) begin
        if (rst && s_valid && out_ready) begin
            if (q_s.size() == 0) chk("s_extra_word", 1, 0);
            else begin
                logic [24:0] e;
                e = q_s.pop_front();
                chk("s_data", 128'(s_data), 128'(e[15:0]));
                chk("s_last", 128'(s_last), 128'(e[24]));
            end
        end
    end

    always @(negedge clk) begin
        if (rst && w_valid && out_ready) begin
            if (q_w.size() == 0) chk("w_extra_word", 1, 0);
            else begin
                logic [24:0] e;
                e = q_w.pop_front();
                chk("w_data", 128'(w_data), 128'(e[15:0]));
                chk("w_last", 128'(w_last), 128'(e[24]));
            end
        end
    end

    // down_out must always be the previous cycle's up_in
    always @(posedge clk) begin
        up_prev <= up_in;
        dn_ok   <= rst;
    end

    always @(negedge clk) begin
        if (rst && dn_ok) chk("down_out_delay", m_down, up_prev);
    end

    task automatic run_job(input string name, input int k, input logic [DW-1:0] l,
                           input logic [N*DW-1:0] up, input logic [31:0] vpat,
                           input bit bp, input bit drain_start, input bit chk_lat);
        int  nacc, i, cyc, stall;
        bit  stalled, pulsed, got_done;
        logic [23:0] hold_exp;
        nacc = 0; i = 0; cyc = 0; stall = 0;
        stalled = 0; pulsed = 0; got_done = 0;
        for (int j = 0; j < N; j++) begin
            int u;
            u = int'(up[(N-j)*DW-1 -: DW]);
            q_m.push_back({1'(j == N - 1), model(24, 0, k, int'(l), u)});
            q_s.push_back({1'(j == N - 1), model(16, 1, k, int'(l), u)});
            q_w.push_back({1'(j == N - 1), model(16, 0, k, int'(l), u)});
        end
        hold_exp   = model(24, 0, k, int'(l), int'(up[(N-2)*DW-1 -: DW]));
        words_main = 0;
        left_in    = l;
        up_in      = up;
        k_len      = 16'(k);
        start      = 1'b1;
        tick();
        cyc   = 1;
        start = 1'b0;
        chk({name, "_busy_rise"}, 128'(m_busy), 1);
        for (int c = 0; c < 400; c++) begin
            if (stall > 0) begin
                chk({name, "_hold_valid"}, 128'(m_valid), 1);
                chk({name, "_hold_data"}, 128'(m_data), 128'(hold_exp));
                stall--;
                if (stall == 0) out_ready = 1'b1;
            end else if (bp && !stalled && words_main == 2 && m_valid) begin
                out_ready = 1'b0;
                stall     = 5;
                stalled   = 1;
            end
            if (drain_start && !pulsed && words_main == 5) begin
                start  = 1'b1;
                k_len  = 16'd7;
                pulsed = 1;
            end else begin
                start = 1'b0;
            end
            if (nacc < k) begin
                left_vld = (i < 32) ? vpat[i] : 1'b1;
                nacc += int'(left_vld);
                i++;
            end else begin
                left_vld = 1'b0;
            end
            tick();
            cyc++;
            if (m_done) begin
                got_done = 1;
                break;
            end
        end
        start = 1'b0;
        left_vld = 1'b0;
        out_ready = 1'b1;
        chk({name, "_done_seen"}, 128'(got_done), 1);
        if (chk_lat) chk({name, "_latency"}, 128'(cyc), 128'(i + 2 * N + (stalled ? 5 : 0)));
        chk({name, "_busy_idle"}, 128'(m_busy), 0);
        chk({name, "_words_left"}, 128'(q_m.size() + q_s.size() + q_w.size()), 0);
        tick();
        chk({name, "_done_once"}, 128'(m_done), 0);
        chk({name, "_no_restart"}, 128'(m_busy), 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; k_len = '0; left_in = '0; left_vld = 1'b0;
        up_in = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 128'(m_busy), 0);
        chk("rst_down", m_down, 0);
        chk("rst_data", 128'(m_data), 0);
        chk("rst_valid", 128'(m_valid), 0);
        chk("rst_last", 128'(m_last), 0);
        chk("rst_done", 128'(m_done), 0);
        rst = 1'b1;
        tick();

        run_job("basic", 3, 8'd2, fill(3), 32'hFFFF_FFFF, 0, 0, 1);
        run_job("bubbles", 2, 8'd5, fill(7), 32'hFFFF_FFF9, 0, 0, 1);
        run_job("width", 2, 8'd255, fill(255), 32'hFFFF_FFFF, 0, 0, 1);
        run_job("backpressure", 3, 8'd4, ramp(1), 32'hFFFF_FFFF, 1, 0, 1);
        run_job("klen0", 0, 8'd9, fill(9), 32'hFFFF_FFFF, 0, 0, 0);
        run_job("start_in_drain", 2, 8'd6, ramp(10), 32'hFFFF_FFFF, 0, 1, 1);

        // Reset in the middle of accumulation, then a fresh job
        left_in = 8'd3; up_in = fill(4); k_len = 16'd5; left_vld = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_busy", 128'(m_busy), 0);
        chk("midrst_down", m_down, 0);
        chk("midrst_data", 128'(m_data), 0);
        chk("midrst_valid", 128'(m_valid), 0);
        chk("midrst_last", 128'(m_last), 0);
        chk("midrst_done", 128'(m_done), 0);
        left_vld = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("postrst_busy", 128'(m_busy), 0);
        run_job("after_reset", 1, 8'd1, fill(1), 32'hFFFF_FFFF, 0, 0, 1);

        for (int c = 0; c < 20; c++) begin
            up_in = {$urandom, $urandom, $urandom, $urandom};
            tick();
            chk("down_out_rand", m_down, up_in);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
